data_memory_be: RTL and testbench

DATA_MEMORY_BE -- requirements
Module: data_memory_be

---
 rtl/data_memory_be_if.sv | 26 ++
 rtl/data_memory_be.sv | 156 +++++++++++++++
 tb/tb_data_memory_be.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/data_memory_be_if.sv
// Request/response bundle for the byte-enabled data memory.
// The master drives the request; the slave returns load data and status pulses.
interface data_memory_be_if #(
    parameter int unsigned ADDR_W = 10
);
    logic              req;
    logic              we;
    logic [1:0]        size;
    logic              unsigned_ld;
    logic [ADDR_W-1:0] address;
    logic [31:0]       data_in;
    logic [31:0]       data_out;
    logic              rvalid;
    logic              misaligned;
    logic              busy;

    modport master (
        output req, we, size, unsigned_ld, address, data_in,
        input  data_out, rvalid, misaligned, busy
    );

    modport slave (
        input  req, we, size, unsigned_ld, address, data_in,
        output data_out, rvalid, misaligned, busy
    );
endinterface

// File: rtl/data_memory_be.sv
// Word-organised data memory with byte/half/word lane access and sign/zero-extending loads.
// An optional clear engine zeroes every word after reset, one word per cycle.
module data_memory_be #(
    parameter int unsigned ADDR_W         = 10,
    parameter bit          CLEAR_ON_RESET = 1'b1
) (
    input  logic             CLK,
    input  logic             reset,
    data_memory_be_if.slave  bus
);
    localparam int unsigned IDX_W = ADDR_W - 2;
    localparam int unsigned DEPTH = 1 << IDX_W;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } state_t;

    localparam state_t RST_STATE = CLEAR_ON_RESET ? ST_CLEAR : ST_IDLE;

    logic [31:0]      r_mem [DEPTH];

    state_t           r_state;
    state_t           w_state_nxt;
    logic [IDX_W-1:0] r_clr_ptr;
    logic [IDX_W-1:0] w_clr_ptr_nxt;
    logic [31:0]      r_data_out;
    logic [31:0]      w_data_out_nxt;
    logic             r_rvalid;
    logic             w_rvalid_nxt;
    logic             r_misaligned;
    logic             w_misaligned_nxt;
    logic             r_busy;
    logic             w_busy_nxt;

    logic [IDX_W-1:0] w_idx;
    logic [1:0]       w_lane;
    logic             w_mis;
    logic [31:0]      w_rd_word;
    logic [15:0]      w_rd_half;
    logic [31:0]      w_load_data;
    logic [3:0]       w_be;
    logic [31:0]      w_wdata;
    logic             w_st_we;
    logic             w_clr_we;

    assign w_idx  = bus.address[ADDR_W-1:2];
    assign w_lane = bus.address[1:0];

    assign w_mis = ((bus.size == 2'b01) && w_lane[0])
                 || ((bus.size == 2'b10) && (w_lane != 2'b00))
                 ||  (bus.size == 2'b11);

    // Low half of the word shifted down to the addressed lane
    assign w_rd_word = r_mem[w_idx];
    assign w_rd_half = 16'(w_rd_word >> {w_lane, 3'b000});

    always_comb begin
        case (bus.size)
            2'b00:   w_load_data = bus.unsigned_ld ? {24'h0, w_rd_half[7:0]}
                                                   : {{24{w_rd_half[7]}}, w_rd_half[7:0]};
            2'b01:   w_load_data = bus.unsigned_ld ? {16'h0, w_rd_half}
                                                   : {{16{w_rd_half[15]}}, w_rd_half};
            default: w_load_data = w_rd_word;
        endcase
    end

    // Store data is replicated across lanes; the byte enables pick the live ones
    always_comb begin
        case (bus.size)
            2'b00: begin
                w_be    = 4'(4'b0001 << w_lane);
                w_wdata = {4{bus.data_in[7:0]}};
            end
            2'b01: begin
                w_be    = 4'(4'b0011 << w_lane);
                w_wdata = {2{bus.data_in[15:0]}};
            end
            default: begin
                w_be    = 4'hF;
                w_wdata = bus.data_in;
            end
        endcase
    end

    assign w_st_we  = bus.req && bus.we && !w_mis && (r_state == ST_IDLE) && !reset;
    assign w_clr_we = (r_state == ST_CLEAR) && !reset;

    always_comb begin
        w_state_nxt      = r_state;
        w_clr_ptr_nxt    = r_clr_ptr;
        w_data_out_nxt   = r_data_out;
        w_rvalid_nxt     = 1'b0;
        w_misaligned_nxt = 1'b0;
        case (r_state)
            ST_CLEAR: begin
                w_clr_ptr_nxt = IDX_W'(r_clr_ptr + 1'b1);
                if (r_clr_ptr == IDX_W'(DEPTH - 1)) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (bus.req) begin
                    if (w_mis) begin
                        w_misaligned_nxt = 1'b1;
                        if (!bus.we) begin
                            w_rvalid_nxt   = 1'b1;
                            w_data_out_nxt = 32'h0;
                        end
                    end else if (!bus.we) begin
                        w_rvalid_nxt   = 1'b1;
                        w_data_out_nxt = w_load_data;
                    end
                end
            end
            default: w_state_nxt = RST_STATE;
        endcase
        w_busy_nxt = (w_state_nxt == ST_CLEAR);
    end

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            r_state      <= RST_STATE;
            r_clr_ptr    <= '0;
            r_data_out   <= 32'h0;
            r_rvalid     <= 1'b0;
            r_misaligned <= 1'b0;
            r_busy       <= 1'(CLEAR_ON_RESET);
        end else begin
            r_state      <= w_state_nxt;
            r_clr_ptr    <= w_clr_ptr_nxt;
            r_data_out   <= w_data_out_nxt;
            r_rvalid     <= w_rvalid_nxt;
            r_misaligned <= w_misaligned_nxt;
            r_busy       <= w_busy_nxt;
        end
    end

    // Storage array carries no reset; the clear engine zeroes it instead
    always_ff @(posedge CLK) begin
        if (w_clr_we) begin
            r_mem[r_clr_ptr] <= 32'h0;
        end else if (w_st_we) begin
            for (int i = 0; i < 4; i++) begin
                if (w_be[i]) begin
                    r_mem[w_idx][8*i +: 8] <= w_wdata[8*i +: 8];
                end
            end
        end
    end

    assign bus.data_out   = r_data_out;
    assign bus.rvalid     = r_rvalid;
    assign bus.misaligned = r_misaligned;
    assign bus.busy       = r_busy;
endmodule

// File: tb/tb_data_memory_be.sv
// Directed bench for data_memory_be: expected responses are queued when a request
// is driven and checked against the DUT output in the cycle it must appear.
module tb_data_memory_be;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    typedef struct {
        int          cyc;
        logic        rv;
        logic        mis;
        logic        chk;
        logic [31:0] data;
        int          id;
    } exp_t;

    exp_t sb[$];
    exp_t e_mon;

    data_memory_be_if #(.ADDR_W(10)) bus ();

    data_memory_be #(
        .ADDR_W(10),
        .CLEAR_ON_RESET(1'b1)
    ) dut (
        .CLK   (clk),
        .reset (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Response monitor: each queued entry must be met exactly in its cycle
    always @(negedge clk) begin
        if (!rst) begin
            if (sb.size() > 0 && sb[0].cyc < cyc) begin
                check($sformatf("missed_resp_%0d", sb[0].id), 32'(cyc), 32'(sb[0].cyc));
                void'(sb.pop_front());
            end
            if (sb.size() > 0 && sb[0].cyc == cyc) begin
                e_mon = sb.pop_front();
                check($sformatf("rvalid_%0d", e_mon.id), {31'h0, bus.rvalid}, {31'h0, e_mon.rv});
                check($sformatf("misaligned_%0d", e_mon.id), {31'h0, bus.misaligned}, {31'h0, e_mon.mis});
                if (e_mon.chk) begin
                    check($sformatf("data_%0d", e_mon.id), bus.data_out, e_mon.data);
                end
            end else begin
                check("no_spurious_pulse", {30'h0, bus.rvalid, bus.misaligned}, 32'h0);
            end
        end
    end

    task automatic op(input logic w, input logic [1:0] sz, input logic u, input logic [9:0] a,
                      input logic [31:0] d, input logic exp_mis, input logic [31:0] exp_d, input int id);
        exp_t e;
        @(negedge clk);
        bus.req         = 1'b1;
        bus.we          = w;
        bus.size        = sz;
        bus.unsigned_ld = u;
        bus.address     = a;
        bus.data_in     = d;
        if (!w || exp_mis) begin
            e.cyc  = cyc + 1;
            e.rv   = !w;
            e.mis  = exp_mis;
            e.chk  = !w;
            e.data = exp_d;
            e.id   = id;
            sb.push_back(e);
        end
    endtask

    task automatic idle();
        @(negedge clk);
        bus.req = 1'b0;
    endtask

    initial begin
        int n;
        bus.req         = 1'b0;
        bus.we          = 1'b0;
        bus.size        = 2'b00;
        bus.unsigned_ld = 1'b0;
        bus.address     = '0;
        bus.data_in     = '0;

        #1 rst = 1'b1;
        #2;
        check("rst_data_out", bus.data_out, 32'h0);
        check("rst_rvalid", {31'h0, bus.rvalid}, 32'h0);
        check("rst_misaligned", {31'h0, bus.misaligned}, 32'h0);
        check("rst_busy", {31'h0, bus.busy}, 32'h1);
        @(negedge clk);
        rst = 1'b0;

        // Abort the clear part-way through
        repeat (100) @(negedge clk);
        check("busy_mid_clear", {31'h0, bus.busy}, 32'h1);
        #2 rst = 1'b1;
        #1 check("busy_in_reset", {31'h0, bus.busy}, 32'h1);
        @(negedge clk);
        rst = 1'b0;

        // Clear must run a full 256 cycles; requests during it are ignored
        n = 0;
        while (n < 400) begin
            @(negedge clk);
            n++;
            if (!bus.busy) break;
            if (n >= 3 && n <= 20) begin
                bus.req     = 1'b1;
                bus.we      = n[0];
                bus.size    = (n % 3 == 0) ? 2'b11 : 2'b10;
                bus.address = 10'h000;
                bus.data_in = 32'hFFFF_FFFF;
            end else begin
                bus.req = 1'b0;
            end
        end
        bus.req = 1'b0;
        check("clear_cycles", 32'(n), 32'd256);
        check("data_out_after_clear", bus.data_out, 32'h0);

        op(1'b0, 2'b10, 1'b0, 10'h000, 32'h0, 1'b0, 32'h0000_0000, 1);
        op(1'b0, 2'b10, 1'b0, 10'h3FC, 32'h0, 1'b0, 32'h0000_0000, 2);
        idle();

        op(1'b1, 2'b10, 1'b0, 10'h010, 32'h1122_3344, 1'b0, 32'h0, 3);
        op(1'b1, 2'b00, 1'b0, 10'h012, 32'h1234_56AB, 1'b0, 32'h0, 4);
        op(1'b0, 2'b10, 1'b0, 10'h010, 32'h0, 1'b0, 32'h11AB_3344, 5);
        op(1'b0, 2'b00, 1'b0, 10'h012, 32'h0, 1'b0, 32'hFFFF_FFAB, 6);
        op(1'b0, 2'b00, 1'b1, 10'h012, 32'h0, 1'b0, 32'h0000_00AB, 7);
        op(1'b0, 2'b01, 1'b0, 10'h012, 32'h0, 1'b0, 32'h0000_11AB, 8);
        op(1'b0, 2'b01, 1'b0, 10'h010, 32'h0, 1'b0, 32'h0000_3344, 9);
        op(1'b0, 2'b00, 1'b0, 10'h013, 32'h0, 1'b0, 32'h0000_0011, 10);
        op(1'b1, 2'b01, 1'b0, 10'h010, 32'h5555_BEEF, 1'b0, 32'h0, 11);
        op(1'b0, 2'b01, 1'b1, 10'h010, 32'h0, 1'b0, 32'h0000_BEEF, 12);
        op(1'b0, 2'b01, 1'b0, 10'h010, 32'h0, 1'b0, 32'hFFFF_BEEF, 13);
        op(1'b0, 2'b10, 1'b0, 10'h010, 32'h0, 1'b0, 32'h11AB_BEEF, 14);
        idle();

        op(1'b1, 2'b10, 1'b0, 10'h020, 32'hCAFE_F00D, 1'b0, 32'h0, 15);
        op(1'b1, 2'b01, 1'b0, 10'h021, 32'hFFFF_FFFF, 1'b1, 32'h0, 16);
        idle();
        op(1'b0, 2'b10, 1'b0, 10'h022, 32'h0, 1'b1, 32'h0000_0000, 17);
        op(1'b0, 2'b10, 1'b0, 10'h020, 32'h0, 1'b0, 32'hCAFE_F00D, 18);
        op(1'b0, 2'b11, 1'b0, 10'h024, 32'h0, 1'b1, 32'h0000_0000, 19);
        op(1'b0, 2'b01, 1'b0, 10'h023, 32'h0, 1'b1, 32'h0000_0000, 20);
        op(1'b1, 2'b11, 1'b0, 10'h020, 32'h0000_0000, 1'b1, 32'h0, 21);
        op(1'b0, 2'b10, 1'b0, 10'h020, 32'h0, 1'b0, 32'hCAFE_F00D, 22);
        idle();

        op(1'b1, 2'b10, 1'b0, 10'h040, 32'hDEAD_BEEF, 1'b0, 32'h0, 23);
        op(1'b0, 2'b10, 1'b0, 10'h040, 32'h0, 1'b0, 32'hDEAD_BEEF, 24);
        op(1'b1, 2'b10, 1'b0, 10'h044, 32'h0102_0304, 1'b0, 32'h0, 25);
        op(1'b0, 2'b10, 1'b0, 10'h040, 32'h0, 1'b0, 32'hDEAD_BEEF, 26);
        op(1'b0, 2'b10, 1'b0, 10'h044, 32'h0, 1'b0, 32'h0102_0304, 27);
        op(1'b0, 2'b10, 1'b0, 10'h040, 32'h0, 1'b0, 32'hDEAD_BEEF, 28);
        op(1'b1, 2'b10, 1'b0, 10'h048, 32'h7777_7777, 1'b0, 32'h0, 29);
        idle();
        check("data_out_hold", bus.data_out, 32'hDEAD_BEEF);

        op(1'b1, 2'b00, 1'b0, 10'h3FF, 32'h0000_0080, 1'b0, 32'h0, 30);
        op(1'b0, 2'b00, 1'b0, 10'h3FF, 32'h0, 1'b0, 32'hFFFF_FF80, 31);
        op(1'b0, 2'b10, 1'b0, 10'h3FC, 32'h0, 1'b0, 32'h8000_0000, 32);
        op(1'b0, 2'b10, 1'b0, 10'h048, 32'h0, 1'b0, 32'h7777_7777, 33);
        idle();

        for (int k = 0; k < 10 && sb.size() > 0; k++) @(negedge clk);
        check("scoreboard_drained", 32'(sb.size()), 32'd0);

        // Asynchronous reset clears the output register without a clock edge
        #2 rst = 1'b1;
        #1;
        check("async_rst_data_out", bus.data_out, 32'h0);
        check("async_rst_busy", {31'h0, bus.busy}, 32'h1);
        check("async_rst_rvalid", {31'h0, bus.rvalid}, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
